// File: rtl/grf_scoreboard_if.sv
// Issue/retire bus between decode/issue, writeback and the GRF hazard scoreboard.
interface grf_scoreboard_if;
    logic        IssueValid;
    logic        IssueUseA;
    logic [4:0]  IssueSrcA;
    logic        IssueUseB;
    logic [4:0]  IssueSrcB;
    logic        IssueWr;
    logic [4:0]  IssueDst;
    logic        RetireValid;
    logic [4:0]  RetireDst;
    logic        Stall;
    logic        Issued;
    logic [31:0] BusyVec;
    logic [4:0]  InFlight;
    logic        RetireErr;

    modport master (
        output IssueValid, IssueUseA, IssueSrcA, IssueUseB, IssueSrcB,
               IssueWr, IssueDst, RetireValid, RetireDst,
        input  Stall, Issued, BusyVec, InFlight, RetireErr
    );

    modport slave (
        input  IssueValid, IssueUseA, IssueSrcA, IssueUseB, IssueSrcB,
               IssueWr, IssueDst, RetireValid, RetireDst,
        output Stall, Issued, BusyVec, InFlight, RetireErr
    );
endinterface

// File: rtl/grf_scoreboard.sv
// Hazard scoreboard for the 32x32 GRF: per-register pending-write counters,
// combinational issue stall, retire bookkeeping and a sticky unmatched-retire flag.
// Register 0 is hardwired: never pending, writes to it are ignored.
module grf_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input logic            Clk,
    input logic            Reset,
    grf_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [4:0]       INF_MAX = 5'(MAX_INFLIGHT);

    logic [CNT_W-1:0] count [32];
    logic [4:0]       inflight;
    logic             retire_err;

    logic             retire_nz;
    logic             retire_hit;
    logic             retire_miss;
    logic             haz_a;
    logic             haz_b;
    logic             haz_dst;
    logic             haz_cap;
    logic             stall;
    logic             issue_wr;
    logic [CNT_W-1:0] cnt_src_a;
    logic [CNT_W-1:0] cnt_src_b;
    logic [CNT_W-1:0] cnt_dst;
    logic [CNT_W-1:0] cnt_ret;

    // Hazard evaluation from current state and current inputs; a retire
    // in the same cycle is forwarded so a dependent issue need not wait.
    always_comb begin
        cnt_src_a   = count[bus.IssueSrcA];
        cnt_src_b   = count[bus.IssueSrcB];
        cnt_dst     = count[bus.IssueDst];
        cnt_ret     = count[bus.RetireDst];

        retire_nz   = bus.RetireValid && (bus.RetireDst != 5'd0);
        retire_hit  = retire_nz && (cnt_ret != '0);
        retire_miss = retire_nz && (cnt_ret == '0);

        haz_a   = bus.IssueUseA && (bus.IssueSrcA != 5'd0) && (cnt_src_a != '0) &&
                  !(retire_hit && (bus.RetireDst == bus.IssueSrcA) && (cnt_src_a == CNT_W'(1)));
        haz_b   = bus.IssueUseB && (bus.IssueSrcB != 5'd0) && (cnt_src_b != '0) &&
                  !(retire_hit && (bus.RetireDst == bus.IssueSrcB) && (cnt_src_b == CNT_W'(1)));
        haz_dst = bus.IssueWr && (bus.IssueDst != 5'd0) && (cnt_dst == CNT_MAX) &&
                  !(retire_hit && (bus.RetireDst == bus.IssueDst));
        haz_cap = bus.IssueWr && (bus.IssueDst != 5'd0) && (inflight == INF_MAX) &&
                  !retire_hit;

        stall    = bus.IssueValid && (haz_a || haz_b || haz_dst || haz_cap);
        issue_wr = bus.IssueValid && !stall && bus.IssueWr && (bus.IssueDst != 5'd0);
    end

    // Per-register pending counters; same-register issue and retire cancel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < 32; r++) count[r] <= '0;
        end else begin
            count[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (issue_wr && (bus.IssueDst == 5'(r)) &&
                    !(retire_hit && (bus.RetireDst == 5'(r))))
                    count[r] <= count[r] + CNT_W'(1);
                else if (retire_hit && (bus.RetireDst == 5'(r)) &&
                         !(issue_wr && (bus.IssueDst == 5'(r))))
                    count[r] <= count[r] - CNT_W'(1);
            end
        end
    end

    // Total pending writes, moves by at most one per cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            inflight <= 5'd0;
        else if (issue_wr && !retire_hit)
            inflight <= inflight + 5'd1;
        else if (retire_hit && !issue_wr)
            inflight <= inflight - 5'd1;
    end

    // Sticky flag for a retire to a register with nothing pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            retire_err <= 1'b0;
        else if (retire_miss)
            retire_err <= 1'b1;
    end

    // Busy vector derived from the counters; register 0 is never busy.
    always_comb begin
        bus.BusyVec = 32'd0;
        for (int r = 1; r < 32; r++) bus.BusyVec[r] = (count[r] != '0);
    end

    assign bus.Stall     = stall;
    assign bus.Issued    = bus.IssueValid && !stall;
    assign bus.InFlight  = inflight;
    assign bus.RetireErr = retire_err;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard (CNT_W=2, MAX_INFLIGHT=4).
module tb_grf_scoreboard;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    grf_scoreboard_if bus ();

    grf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ua, input logic [4:0] sa,
                         input logic ub, input logic [4:0] sb, input logic wr,
                         input logic [4:0] d, input logic rv, input logic [4:0] rd);
        bus.IssueValid  = iv;
        bus.IssueUseA   = ua;
        bus.IssueSrcA   = sa;
        bus.IssueUseB   = ub;
        bus.IssueSrcB   = sb;
        bus.IssueWr     = wr;
        bus.IssueDst    = d;
        bus.RetireValid = rv;
        bus.RetireDst   = rd;
    endtask

    // Advance to the falling edge; state from the previous rising edge is visible.
    task automatic step();
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        #2;
        chk("rst_busy", bus.BusyVec, 32'h0);
        chk("rst_inflight", 32'(bus.InFlight), 0);
        chk("rst_err", 32'(bus.RetireErr), 0);
        chk("rst_stall", 32'(bus.Stall), 0);
        chk("rst_issued", 32'(bus.Issued), 1);

        step(); Reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // write r5
        step(); drive(1, 0, 0, 0, 0, 1, 5, 0, 0); #1;
        chk("w5_issued", 32'(bus.Issued), 1);
        chk("w5_stall", 32'(bus.Stall), 0);
        chk("w5_busy_pre", bus.BusyVec, 32'h0);

        // read r5 while pending
        step(); drive(1, 1, 5, 0, 0, 0, 0, 0, 0); #1;
        chk("w5_busy", bus.BusyVec, 32'h20);
        chk("w5_inflight", 32'(bus.InFlight), 1);
        chk("rawA_stall1", 32'(bus.Stall), 1);
        chk("rawA_issued1", 32'(bus.Issued), 0);
        step(); #1;
        chk("rawA_stall2", 32'(bus.Stall), 1);
        step(); drive(1, 1, 5, 0, 0, 0, 0, 1, 5); #1;
        chk("rawA_fwd_stall", 32'(bus.Stall), 0);
        chk("rawA_fwd_issued", 32'(bus.Issued), 1);

        // r5 drained; start filling r7
        step(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0); #1;
        chk("r5_busy_clr", bus.BusyVec, 32'h0);
        chk("r5_inflight_clr", 32'(bus.InFlight), 0);
        step();
        step(); #1;
        chk("w7_third_issued", 32'(bus.Issued), 1);
        step(); #1;
        chk("w7_sat_inflight", 32'(bus.InFlight), 3);
        chk("w7_sat_stall", 32'(bus.Stall), 1);
        step(); drive(1, 0, 0, 0, 0, 1, 7, 1, 7); #1;
        chk("w7_sat_ret_issued", 32'(bus.Issued), 1);
        step(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0); #1;
        chk("w7_cnt_kept_inflight", 32'(bus.InFlight), 3);
        chk("w7_cnt_kept_stall", 32'(bus.Stall), 1);
        chk("w7_busy", bus.BusyVec, 32'h80);

        // drain r7
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        step();
        step();
        step(); drive(1, 0, 0, 0, 0, 1, 1, 0, 0); #1;
        chk("r7_drained_inflight", 32'(bus.InFlight), 0);
        chk("r7_drained_busy", bus.BusyVec, 32'h0);

        // capacity: r1..r4
        step(); drive(1, 0, 0, 0, 0, 1, 2, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step(); drive(1, 0, 0, 0, 0, 1, 6, 0, 0); #1;
        chk("cap_inflight", 32'(bus.InFlight), 4);
        chk("cap_busy", bus.BusyVec, 32'h1E);
        chk("cap_stall", 32'(bus.Stall), 1);
        step(); drive(1, 1, 8, 1, 9, 0, 0, 0, 0); #1;
        chk("cap_nowrite_issued", 32'(bus.Issued), 1);
        step(); drive(1, 0, 0, 0, 0, 1, 0, 0, 0); #1;
        chk("cap_dst0_issued", 32'(bus.Issued), 1);
        step(); drive(1, 0, 0, 0, 0, 1, 6, 1, 1); #1;
        chk("cap_dst0_inflight", 32'(bus.InFlight), 4);
        chk("cap_ret_issued", 32'(bus.Issued), 1);
        step(); drive(1, 1, 0, 1, 3, 0, 0, 0, 0); #1;
        chk("cap_swap_inflight", 32'(bus.InFlight), 4);
        chk("cap_swap_busy", bus.BusyVec, 32'h5C);
        chk("rawB_stall", 32'(bus.Stall), 1);

        // unmatched retire
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 9); #1;
        chk("err_pre", 32'(bus.RetireErr), 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("err_set", 32'(bus.RetireErr), 1);
        chk("err_inflight", 32'(bus.InFlight), 4);
        chk("err_busy", bus.BusyVec, 32'h5C);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("err_sticky", 32'(bus.RetireErr), 1);
        chk("ret0_busy", bus.BusyVec, 32'h5C);

        // asynchronous reset mid-cycle
        #2; Reset = 1'b1; #1;
        chk("async_busy", bus.BusyVec, 32'h0);
        chk("async_inflight", 32'(bus.InFlight), 0);
        chk("async_err", 32'(bus.RetireErr), 0);
        step(); Reset = 1'b0;
        step(); drive(1, 1, 3, 0, 0, 0, 0, 0, 0); #1;
        chk("post_rst_stall", 32'(bus.Stall), 0);
        chk("post_rst_issued", 32'(bus.Issued), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
